// File: rtl/d_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : d_write_buffer
// Purpose  : Store-side write buffer for the data cache. Queues word stores
//            from the MEM stage in a circular FIFO and drains them one at a
//            time into data memory, so the pipeline does not wait on memory
//            write latency. Back-pressures the pipeline when full.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   WE/A/WD    in   store request, byte address (A[1:0] ignored), data
//   LE/LA      in   load valid and load byte address (LA[1:0] ignored)
//   STALL      out  hold the MEM stage this cycle (combinational)
//   FULL/EMPTY out  occupancy flags from the registered count
//   FWD_HIT    out  load satisfied from buffer (combinational)
//   FWD_RD     out  forwarded load data (combinational)
//   MWE/MA/MWD out  registered memory write request, word address, data
//   MREADY     in   one-cycle write-complete pulse from memory
//   FILL_BUSY  in   cache line fill owns memory; no new write may start
// Configuration
//   WB_FORWARD_EN  defined: loads hitting a buffered address are forwarded
//                  the youngest matching data. Undefined: such loads stall
//                  until every matching entry has drained.
// ============================================================================
module d_write_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WE,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] WD,
    input  logic          LE,
    input  logic [AW-1:0] LA,
    output logic          STALL,
    output logic          FULL,
    output logic          EMPTY,
    output logic          FWD_HIT,
    output logic [DW-1:0] FWD_RD,
    output logic          MWE,
    output logic [AW-1:0] MA,
    output logic [DW-1:0] MWD,
    input  logic          MREADY,
    input  logic          FILL_BUSY
);

    localparam int              PW         = $clog2(DEPTH);
    localparam logic [PW:0]     c_FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]     c_CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]   c_PTR_ONE  = PW'(1);

    localparam logic [0:0]      c_IDLE     = 1'b0;
    localparam logic [0:0]      c_WAIT     = 1'b1;

    logic [AW-3:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [0:0]    r_state;
    logic          r_mwe;
    logic [AW-1:0] r_ma;
    logic [DW-1:0] r_mwd;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_hit;
`ifdef WB_FORWARD_EN
    logic [DW-1:0] w_fwd_data;
`endif

    // Byte-offset bits of the word addresses carry no information here.
    logic          w_unused_bits;
    assign w_unused_bits = &{1'b0, A[1:0], LA[1:0]};

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    // Acceptance looks only at the pre-edge count: a full buffer refuses the
    // store even if the head retires on the same edge.
    assign w_push  = WE && !w_full;
    assign w_pop   = (r_state == c_WAIT) && MREADY;

    assign FULL  = w_full;
    assign EMPTY = w_empty;
    assign MWE   = r_mwe;
    assign MA    = r_ma;
    assign MWD   = r_mwd;

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= A[AW-1:2];
            r_data[r_tail] <= WD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= c_IDLE;
            r_mwe   <= 1'b0;
            r_ma    <= '0;
            r_mwd   <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            case (r_state)
                c_IDLE: begin
                    // MREADY here belongs to no request and is ignored.
                    if (!w_empty && !FILL_BUSY) begin
                        r_ma    <= {r_addr[r_head], 2'b00};
                        r_mwd   <= r_data[r_head];
                        r_mwe   <= 1'b1;
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    // FILL_BUSY is not consulted: a started write completes.
                    if (MREADY) begin
                        r_mwe   <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_mwe   <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Scan valid entries oldest to youngest (the in-flight head is still
    // valid until popped); the last match is the youngest store.
    always_comb begin
        w_hit = 1'b0;
`ifdef WB_FORWARD_EN
        w_fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (LE && ((PW+1)'(k) < r_count) &&
                (r_addr[r_head + PW'(k)] == LA[AW-1:2])) begin
                w_hit = 1'b1;
`ifdef WB_FORWARD_EN
                w_fwd_data = r_data[r_head + PW'(k)];
`endif
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign FWD_HIT = w_hit;
    assign FWD_RD  = w_fwd_data;
    assign STALL   = WE && w_full;
`else
    assign FWD_HIT = 1'b0;
    assign FWD_RD  = '0;
    assign STALL   = (WE && w_full) || w_hit;
`endif

endmodule
`default_nettype wire
